// File: rtl/z8086_pkg.sv
// Shared constants and helpers for the z8086 interrupt controller.
package z8086_pkg;

  // Register offsets from the I/O base address.
  localparam logic [15:0] REG_CMD   = 16'd0;
  localparam logic [15:0] REG_IMR   = 16'd2;
  localparam logic [15:0] REG_VBASE = 16'd4;
  localparam logic [15:0] REG_ISR   = 16'd6;

  // Command codes carried in data[7:5] of a command-register write.
  localparam logic [2:0] EOI_NS = 3'b001;
  localparam logic [2:0] EOI_SP = 3'b011;

  // Lowest-index set bit wins; returns {valid, index}.
  function automatic logic [3:0] prio_enc8(input logic [7:0] v);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        r = {1'b1, 3'(i)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/z8086_pic_sync.sv
// Two-flop synchroniser for the eight IRQ lines plus rising-edge detect.
module z8086_pic_sync
  import z8086_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq,
  output logic [7:0] irq_s2,
  output logic [7:0] irq_rise
);

  logic [7:0] s1_r;
  logic [7:0] s2_r;
  logic [7:0] s2_d_r;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_r   <= 8'h00;
      s2_r   <= 8'h00;
      s2_d_r <= 8'h00;
    end else begin
      s1_r   <= irq;
      s2_r   <= s1_r;
      s2_d_r <= s2_r;
    end
  end

  assign irq_s2   = s2_r;
  assign irq_rise = s2_r & ~s2_d_r;

endmodule

// File: rtl/z8086_pic.sv
// z8086 interrupt controller: IRR/ISR/IMR, priority resolution, INTA vector
// responder and I/O-mapped register access on the CPU bus.
module z8086_pic
  import z8086_pkg::*;
#(
  parameter logic [15:0] IO_BASE     = 16'h0020,
  parameter logic [7:0]  LEVEL_MASK  = 8'h00,
  parameter logic [4:0]  RESET_VBASE = 5'h01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  irq,
  input  logic [19:0] addr,
  input  logic [15:0] wdata,
  input  logic        wr,
  input  logic        rd,
  input  logic        io,
  input  logic        word,
  input  logic        inta,
  output logic        intr,
  output logic [15:0] rd_data,
  output logic        ready,
  output logic        sel
);

  logic [7:0]  irq_s2_s;
  logic [7:0]  irq_rise_s;
  logic [7:0]  irr_r, isr_r, imr_r;
  logic [4:0]  vbase_r;
  logic        inta_d_r;

  logic [7:0]  irr_next_s, isr_next_s, imr_next_s;
  logic [4:0]  vbase_next_s;
  logic [3:0]  isr_enc_s, sel_enc_s;
  logic [7:0]  req_s, below_s, ack_mask_s, eoi_mask_s;
  logic        inta_rise_s, hit_cmd_s, hit_imr_s, hit_vbase_s, hit_isr_s, hit_s;
  logic        intr_next_s, ready_next_s;
  logic [15:0] rd_data_next_s;
  logic        unused_s;

  // Upper address bits, the width qualifier and the high data byte play no role.
  assign unused_s = ^{addr[19:16], word, wdata[15:8]};

  z8086_pic_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .irq      (irq),
    .irq_s2   (irq_s2_s),
    .irq_rise (irq_rise_s)
  );

  // Priority resolution, INTA acknowledge, register decode and next state.
  always_comb begin
    req_s     = irr_r & ~imr_r;
    isr_enc_s = prio_enc8(isr_r);
    // Only requests strictly above the highest in-service level may interrupt.
    if (isr_enc_s[3]) begin
      below_s = (8'h01 << isr_enc_s[2:0]) - 8'h01;
    end else begin
      below_s = 8'hFF;
    end
    sel_enc_s   = prio_enc8(req_s & below_s);
    inta_rise_s = inta & ~inta_d_r;
    if (inta_rise_s && sel_enc_s[3]) begin
      ack_mask_s = 8'h01 << sel_enc_s[2:0];
    end else begin
      ack_mask_s = 8'h00;
    end

    hit_cmd_s   = io && (addr[15:0] == IO_BASE + REG_CMD);
    hit_imr_s   = io && (addr[15:0] == IO_BASE + REG_IMR);
    hit_vbase_s = io && (addr[15:0] == IO_BASE + REG_VBASE);
    hit_isr_s   = io && (addr[15:0] == IO_BASE + REG_ISR);
    hit_s       = (hit_cmd_s || hit_imr_s || hit_vbase_s || hit_isr_s) && (wr || rd);

    eoi_mask_s = 8'h00;
    if (wr && hit_cmd_s) begin
      case (wdata[7:5])
        EOI_NS:  eoi_mask_s = isr_enc_s[3] ? (8'h01 << isr_enc_s[2:0]) : 8'h00;
        EOI_SP:  eoi_mask_s = 8'h01 << wdata[2:0];
        default: eoi_mask_s = 8'h00;
      endcase
    end else begin
      eoi_mask_s = 8'h00;
    end

    // A fresh edge wins over an acknowledge clear in the same cycle.
    irr_next_s = (LEVEL_MASK & irq_s2_s) |
                 (~LEVEL_MASK & ((irr_r & ~ack_mask_s) | irq_rise_s));
    isr_next_s = (isr_r & ~eoi_mask_s) | ack_mask_s;

    if (wr && hit_imr_s) begin
      imr_next_s = wdata[7:0];
    end else begin
      imr_next_s = imr_r;
    end
    if (wr && hit_vbase_s) begin
      vbase_next_s = wdata[7:3];
    end else begin
      vbase_next_s = vbase_r;
    end

    intr_next_s = sel_enc_s[3] & ~inta;

    // INTA takes the bus; a coincident register read is dropped.
    if (inta_rise_s) begin
      ready_next_s   = 1'b1;
      rd_data_next_s = {8'h00, vbase_r, sel_enc_s[3] ? sel_enc_s[2:0] : 3'd7};
    end else if (hit_s) begin
      ready_next_s = 1'b1;
      if (!rd) begin
        rd_data_next_s = 16'h0000;
      end else if (hit_cmd_s) begin
        rd_data_next_s = {8'h00, irr_r};
      end else if (hit_imr_s) begin
        rd_data_next_s = {8'h00, imr_r};
      end else if (hit_vbase_s) begin
        rd_data_next_s = {8'h00, vbase_r, 3'b000};
      end else begin
        rd_data_next_s = {8'h00, isr_r};
      end
    end else begin
      ready_next_s   = 1'b0;
      rd_data_next_s = 16'h0000;
    end
  end

  // Controller state and registered bus/CPU outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irr_r    <= 8'h00;
      isr_r    <= 8'h00;
      imr_r    <= 8'hFF;
      vbase_r  <= RESET_VBASE;
      inta_d_r <= 1'b0;
      intr     <= 1'b0;
      ready    <= 1'b0;
      sel      <= 1'b0;
      rd_data  <= 16'h0000;
    end else begin
      irr_r    <= irr_next_s;
      isr_r    <= isr_next_s;
      imr_r    <= imr_next_s;
      vbase_r  <= vbase_next_s;
      inta_d_r <= inta;
      intr     <= intr_next_s;
      ready    <= ready_next_s;
      sel      <= ready_next_s;
      rd_data  <= rd_data_next_s;
    end
  end

endmodule

// File: tb/tb_z8086_pic.sv
// Scoreboard bench for z8086_pic: expected bus/vector data is queued when a
// transaction is driven and compared when ready is seen.
module tb_z8086_pic;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq = 8'h00;
  logic [19:0] addr = 20'h0;
  logic [15:0] wdata = 16'h0;
  logic        wr = 1'b0, rd = 1'b0, io = 1'b0, word = 1'b0, inta = 1'b0;
  logic        intr, ready, sel;
  logic [15:0] rd_data;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];
  string       mon_tag;
  logic [15:0] mon_exp;

  z8086_pic #(.IO_BASE(16'h0020), .LEVEL_MASK(8'h01), .RESET_VBASE(5'h01)) dut (
    .clk(clk), .reset(reset), .irq(irq), .addr(addr), .wdata(wdata),
    .wr(wr), .rd(rd), .io(io), .word(word), .inta(inta),
    .intr(intr), .rd_data(rd_data), .ready(ready), .sel(sel)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %04h expected %04h", tag, got, exp);
    end
  endtask

  // Scoreboard monitor: every ready pops one expected value; idle bus must be 0.
  always @(negedge clk) begin
    if (!reset) begin
      if (ready) begin
        check_val("sel_with_ready", {15'd0, sel}, 16'd1);
        if (exp_q.size() == 0) begin
          check_val("unexpected_ready", {15'd0, ready}, 16'd0);
        end else begin
          mon_tag = tag_q.pop_front();
          mon_exp = exp_q.pop_front();
          check_val(mon_tag, rd_data, mon_exp);
        end
      end else begin
        check_val("idle_sel", {15'd0, sel}, 16'd0);
        check_val("idle_rd_data", rd_data, 16'h0000);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_wr(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    exp_q.push_back(16'h0000); tag_q.push_back("wr_ack");
    addr = {4'h0, a}; wdata = d; io = 1'b1; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0; io = 1'b0;
  endtask

  task automatic bus_rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    @(negedge clk);
    exp_q.push_back(exp); tag_q.push_back(tag);
    addr = {4'h0, a}; io = 1'b1; rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; io = 1'b0;
  endtask

  // Held for three cycles so a re-trigger would show up as an extra ready.
  task automatic do_inta(input logic [15:0] exp, input string tag);
    @(negedge clk);
    exp_q.push_back(exp); tag_q.push_back(tag);
    inta = 1'b1;
    @(negedge clk);
    check_val({tag, "_intr_drop"}, {15'd0, intr}, 16'd0);
    tick(2);
    inta = 1'b0;
  endtask

  task automatic wait_intr(input string tag);
    for (int i = 0; i < 8; i++) begin
      if (intr) break;
      @(negedge clk);
    end
    check_val(tag, {15'd0, intr}, 16'd1);
  endtask

  task automatic intr_low(input string tag, input int n);
    tick(n);
    check_val(tag, {15'd0, intr}, 16'd0);
  endtask

  task automatic pulse_irq(input logic [7:0] m);
    @(negedge clk);
    irq = irq | m;
    tick(3);
    irq = irq & ~m;
  endtask

  initial begin
    tick(3);
    check_val("rst_intr", {15'd0, intr}, 16'd0);
    check_val("rst_ready", {15'd0, ready}, 16'd0);
    check_val("rst_sel", {15'd0, sel}, 16'd0);
    check_val("rst_rd_data", rd_data, 16'h0000);
    reset = 1'b0;

    // Masked after reset.
    bus_rd(16'h0022, 16'h00FF, "rst_imr");
    pulse_irq(8'h08);
    intr_low("masked_irq3", 6);

    // Unmask IRQ3, acknowledge.
    bus_wr(16'h0022, 16'h00F7);
    pulse_irq(8'h08);
    wait_intr("irq3_intr");
    do_inta(16'h000B, "inta_irq3");
    bus_rd(16'h0026, 16'h0008, "isr_after_irq3");
    bus_wr(16'h0020, 16'h0020);

    // Simultaneous IRQ5/IRQ2, EOI releases the lower priority one.
    bus_wr(16'h0022, 16'h0000);
    pulse_irq(8'h24);
    wait_intr("irq2_intr");
    do_inta(16'h000A, "inta_irq2");
    intr_low("irq5_blocked", 4);
    bus_wr(16'h0020, 16'h0020);
    wait_intr("irq5_after_eoi");
    do_inta(16'h000D, "inta_irq5");
    bus_wr(16'h0020, 16'h0020);

    // Nesting: IRQ1 preempts IRQ4, specific EOI clears only bit 1.
    pulse_irq(8'h10);
    wait_intr("irq4_intr");
    do_inta(16'h000C, "inta_irq4");
    pulse_irq(8'h02);
    wait_intr("irq1_nest_intr");
    do_inta(16'h0009, "inta_irq1");
    bus_rd(16'h0026, 16'h0012, "isr_nested");
    bus_wr(16'h0020, 16'h0061);
    bus_rd(16'h0026, 16'h0010, "isr_after_spec_eoi");
    bus_wr(16'h0020, 16'h0020);

    // Level-sensitive IRQ0 with relocated vector base.
    bus_wr(16'h0024, 16'h0070);
    bus_rd(16'h0024, 16'h0070, "vbase_rd");
    @(negedge clk); irq[0] = 1'b1;
    wait_intr("irq0_intr");
    do_inta(16'h0070, "inta_irq0");
    intr_low("irq0_in_service", 3);
    bus_wr(16'h0020, 16'h0020);
    wait_intr("irq0_level_reassert");
    @(negedge clk); irq[0] = 1'b0;
    intr_low("irq0_released", 5);
    bus_wr(16'h0020, 16'h0020);
    bus_wr(16'h0024, 16'h0008);

    // Spurious INTA coinciding with a register read: only the vector answers.
    @(negedge clk);
    exp_q.push_back(16'h000F); tag_q.push_back("spurious_vec");
    addr = 20'h00022; io = 1'b1; rd = 1'b1; inta = 1'b1;
    @(negedge clk);
    rd = 1'b0; io = 1'b0;
    tick(2);
    inta = 1'b0;
    bus_rd(16'h0026, 16'h0000, "isr_after_spurious");
    bus_rd(16'h0020, 16'h0000, "irr_idle");
    bus_wr(16'h0026, 16'h00FF);
    bus_rd(16'h0026, 16'h0000, "isr_ro");

    // Misses: wrong address, and memory space at a register address.
    @(negedge clk); addr = 20'h00028; io = 1'b1; rd = 1'b1;
    @(negedge clk); addr = 20'h00022; io = 1'b0;
    @(negedge clk); rd = 1'b0;
    tick(2);

    // Reset during INTA.
    pulse_irq(8'h08);
    wait_intr("irq3_before_reset");
    @(negedge clk); inta = 1'b1; reset = 1'b1;
    @(negedge clk);
    check_val("reset_inta_ready", {15'd0, ready}, 16'd0);
    check_val("reset_inta_intr", {15'd0, intr}, 16'd0);
    inta = 1'b0;
    exp_q.delete(); tag_q.delete();
    @(negedge clk); reset = 1'b0;
    bus_rd(16'h0022, 16'h00FF, "imr_after_reset");
    bus_rd(16'h0026, 16'h0000, "isr_after_reset");
    intr_low("intr_after_reset", 2);

    tick(3);
    check_val("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Backstop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/z8086_pic.md
Name: z8086_pic

Overview:
- Interrupt-controller responder for the z8086 maskable interrupt path. It collects 8 external IRQ lines, prioritises them, and drives `intr` to the CPU.
- It answers the CPU's `inta` cycle with an 8-bit vector on the read-data bus.
- It exposes mask, EOI and vector-base registers as I/O ports on the same CPU bus.
- It sits beside the memory/IO decoder. The SoC read-data mux selects `rd_data` when `sel` is high.

Parameters:
- IO_BASE, 16'h0020: base I/O address; the four registers sit at IO_BASE+0/2/4/6.
- LEVEL_MASK, 8'h00: per-IRQ sense select; 1 = level-sensitive, 0 = rising-edge.
- RESET_VBASE, 5'h01: reset value of vector base bits [7:3], so vectors default to 08h..0Fh.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq  in  8  asynchronous interrupt requests; bit 0 has highest priority
- addr  in  20  CPU address; only [15:0] are decoded when io=1
- wdata  in  16  CPU write data (CPU dout)
- wr  in  1  CPU write strobe, single cycle
- rd  in  1  CPU read strobe, single cycle
- io  in  1  I/O-space qualifier
- word  in  1  16-bit access; ignored, registers are 8-bit in data[7:0]
- inta  in  1  interrupt acknowledge from the CPU, level
- intr  out  1  interrupt request to the CPU
- rd_data  out  16  read/vector data; upper byte is always 0
- ready  out  1  one-cycle completion pulse for register access or INTA
- sel  out  1  high in the same cycle as ready; owns the read-data mux

Behaviour:
- Reset values: IRR=0, ISR=0, IMR=8'hFF, VBASE=RESET_VBASE, intr=0, ready=0, sel=0, rd_data=0, sync flops=0, inta_d=0.
- Input sync: each irq bit passes through a 2-flop synchroniser (s2).
- IRR for an edge bit: set on s2 rising edge; cleared when that IRQ is acknowledged. A set and a clear of the same bit in the same cycle resolves to set.
- IRR for a level bit: IRR = s2 every cycle.
- Eligible set: req = IRR & ~IMR.
- Priority ceiling: index of the lowest set ISR bit, or 8 if ISR=0.
- pend: req contains a bit with index below the ceiling.
- intr is registered: intr <= pend & ~inta. intr drops the cycle after inta rises.
- INTA handshake: act on inta & ~inta_d, i.e. once per inta assertion.
  - Cycle T: select the lowest-index eligible bit n below the ceiling. Set ISR[n] and clear IRR[n] if it is an edge bit.
  - Cycle T+1: ready=1, sel=1, rd_data={8'h00, VBASE, n[2:0]}.
  - Spurious INTA (no eligible bit): return {VBASE, 3'd7}; ISR and IRR unchanged.
  - inta held high does not re-trigger the handshake.
- Register access hits only when io=1 and addr[15:0] equals one of the four register addresses. Misses produce no response and sel=0.
- Every hit gives ready=1 and sel=1 on the following cycle.
- Register map:
  - +0: write command; read returns IRR.
    - data[7:5]=3'b001: non-specific EOI, clears the lowest set ISR bit.
    - data[7:5]=3'b011: specific EOI, clears ISR[data[2:0]].
    - Other codes are ignored.
  - +2: IMR, read/write.
  - +4: VBASE; write takes data[7:3], read returns {VBASE, 3'b000}.
  - +6: ISR, read-only; writes are ignored but still ready.
- rd_data is held at 0 whenever sel=0.
- rd and inta edge in the same cycle: INTA has priority; the register read is dropped and gets no ready.
- An IMR write takes effect on the next cycle's intr evaluation.
- Reset mid-INTA aborts the handshake: no ready, and all state returns to reset values.
- Nesting: a higher-priority request arriving while a lower one is in service re-asserts intr. An equal or lower-priority request waits for EOI.

Decomposition:
- z8086_pkg holds:
  - register offset localparams REG_CMD=0, REG_IMR=2, REG_VBASE=4, REG_ISR=6;
  - EOI code constants EOI_NS=3'b001 and EOI_SP=3'b011;
  - a function prio_enc8 returning {valid, idx[2:0]} for the lowest set bit.
- One sub-module, z8086_pic_sync: 8-bit 2-flop synchroniser plus rising-edge detect. Everything else lives in z8086_pic.

Test Plan:
- After reset: read IMR at 0x22 -> 00FF with a one-cycle ready. Pulse irq[3] -> intr stays 0 because the IRQ is masked.
- Write IMR=F7, pulse irq[3] -> intr=1 within 4 cycles. Raise inta -> next cycle rd_data=000B, ready=1; intr falls; reading ISR at 0x26 gives 0008.
- irq[5] and irq[2] rise in the same cycle with IMR=00 -> first INTA returns 000A. Without EOI, a second INTA returns nothing new (intr=0). Write 0x20 to 0x20 (non-specific EOI) -> intr re-asserts and the next INTA returns 000D.
- ISR[4] in service, irq[1] edge arrives -> intr=1 and INTA returns 0009 (nesting). Specific EOI 0x61 clears ISR bit 1 only, leaving ISR=10h.
- Write VBASE=0x70, LEVEL_MASK bit 0 set, hold irq[0] high -> INTA returns 0070. After EOI, intr re-asserts while irq[0] stays high.
- Raise inta with no requests -> rd_data=000F and ISR unchanged. Assert reset mid-INTA -> no ready, intr=0, IMR=FF.
